// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - control-bundle handshake interface for instr_encoder
interface instr_encoder_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_regdst;
  logic       in_alusrc;
  logic       in_memtoreg;
  logic       in_regwrite;
  logic       in_memread;
  logic       in_memwrite;
  logic       in_branch;
  logic [1:0] in_aluop;
  logic [2:0] in_rs;
  logic [2:0] in_rt;
  logic [2:0] in_rd;
  logic [3:0] in_funct;
  logic [7:0] in_imm;
  logic       in_last;

  modport master (
    output in_valid, in_regdst, in_alusrc, in_memtoreg, in_regwrite, in_memread,
           in_memwrite, in_branch, in_aluop, in_rs, in_rt, in_rd, in_funct,
           in_imm, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_regdst, in_alusrc, in_memtoreg, in_regwrite, in_memread,
           in_memwrite, in_branch, in_aluop, in_rs, in_rt, in_rd, in_funct,
           in_imm, in_last,
    output in_ready
  );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - control bundle to 16-bit instruction encoder and imem loader (option: IMM_RANGE_CHECK_EN)
module instr_encoder #(
  parameter int ADDR_W     = 8,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_encoder_if.slave    in_if,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              err_illegal,
  output logic              err_range,
  output logic              full,
  output logic              done
);

  localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);

  typedef enum logic [2:0] {S_IDLE, S_ENC, S_WRITE, S_DONE, S_FULL} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_key;
  logic [2:0]        r_rs;
  logic [2:0]        r_rt;
  logic [2:0]        r_rd;
  logic [3:0]        r_funct;
  logic [7:0]        r_imm;
  logic              r_last;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_full;
  logic              r_err_ill;
  logic              w_legal;
  logic [2:0]        w_op;
  logic              w_imm_bad;
  logic              w_accept;
  logic [15:0]       w_word;
  logic              w_take;
  logic              w_unused;

  assign w_take      = (r_state == S_IDLE) && in_if.in_valid;
  assign in_if.in_ready = rst_n && (r_state == S_IDLE);
  assign done        = (r_state == S_DONE);
  assign full        = r_full;
  assign err_illegal = r_err_ill;
  assign w_unused    = in_if.in_alusrc ^ r_imm[7];

  // Recover the opcode from the captured control bundle; alusrc is deliberately ignored
  always_comb begin
    w_legal = 1'b1;
    w_op    = 3'b000;
    case (r_key)
      8'b1010_0000: w_op = 3'b000;
      8'b0111_0011: w_op = 3'b100;
      8'b0000_1011: w_op = 3'b101;
      8'b0010_0011: w_op = 3'b111;
      8'b0000_0101: w_op = 3'b110;
      8'b0010_0010: w_op = 3'b001;
      default:      w_legal = 1'b0;
    endcase
  end

  // Immediate legality and word packing; R-type never looks at the immediate
  always_comb begin
    w_imm_bad = 1'b0;
`ifdef IMM_RANGE_CHECK_EN
    w_imm_bad = (w_op != 3'b000) && (r_imm[7] != r_imm[6]);
`endif
    w_accept = w_legal && !w_imm_bad;
    if (w_op == 3'b000) begin
      w_word = {w_op, r_rs, r_rt, r_rd, r_funct};
    end else begin
      w_word = {w_op, r_rs, r_rt, r_imm[6:0]};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; count already includes the word being written while in WRITE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_if.in_valid) w_next = S_ENC;
      S_ENC:   begin
        if (w_accept)    w_next = S_WRITE;
        else if (r_last) w_next = S_DONE;
        else             w_next = S_IDLE;
      end
      S_WRITE: begin
        if (r_last)              w_next = S_DONE;
        else if (count == DEPTH) w_next = S_FULL;
        else                     w_next = S_IDLE;
      end
      S_DONE:  if (restart) w_next = S_IDLE;
      S_FULL:  if (restart) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Capture, write port, pointer/count and sticky flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_key     <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_funct   <= '0;
      r_imm     <= '0;
      r_last    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= START;
      mem_wdata <= '0;
      r_ptr     <= START;
      count     <= '0;
      r_full    <= 1'b0;
      r_err_ill <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (w_take) begin
        r_key   <= {in_if.in_regdst, in_if.in_memtoreg, in_if.in_regwrite, in_if.in_memread,
                    in_if.in_memwrite, in_if.in_branch, in_if.in_aluop};
        r_rs    <= in_if.in_rs;
        r_rt    <= in_if.in_rt;
        r_rd    <= in_if.in_rd;
        r_funct <= in_if.in_funct;
        r_imm   <= in_if.in_imm;
        r_last  <= in_if.in_last;
      end
      if (r_state == S_ENC) begin
        if (w_accept) begin
          mem_we    <= 1'b1;
          mem_addr  <= r_ptr;
          mem_wdata <= w_word;
          r_ptr     <= r_ptr + 1'b1;
          count     <= count + 1'b1;
        end else if (!w_legal) begin
          r_err_ill <= 1'b1;
        end
      end
      if ((r_state == S_WRITE) && (count == DEPTH)) begin
        r_full <= 1'b1;
      end
      if (((r_state == S_DONE) || (r_state == S_FULL)) && restart) begin
        r_ptr     <= START;
        count     <= '0;
        r_full    <= 1'b0;
        r_err_ill <= 1'b0;
      end
    end
  end

`ifdef IMM_RANGE_CHECK_EN
  logic r_err_rng;

  // Sticky range error for a legal non-R-type bundle with an out-of-range immediate
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err_rng <= 1'b0;
    end else if (((r_state == S_DONE) || (r_state == S_FULL)) && restart) begin
      r_err_rng <= 1'b0;
    end else if ((r_state == S_ENC) && w_legal && w_imm_bad) begin
      r_err_rng <= 1'b1;
    end
  end

  assign err_range = r_err_rng;
`else
  assign err_range = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder
module tb_instr_encoder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8_n, rst2_n, restart8, restart2;
  instr_encoder_if if8();
  instr_encoder_if if2();

  logic       we8, ill8, rng8, full8, done8;
  logic [7:0] addr8;
  logic [15:0] wdata8;
  logic [8:0] count8;
  logic       we2, ill2, rng2, full2, done2;
  logic [1:0] addr2;
  logic [15:0] wdata2;
  logic [2:0] count2;

  instr_encoder #(.ADDR_W(8), .START_ADDR(0)) dut8 (
    .clk(clk), .rst_n(rst8_n), .in_if(if8), .restart(restart8),
    .mem_we(we8), .mem_addr(addr8), .mem_wdata(wdata8), .count(count8),
    .err_illegal(ill8), .err_range(rng8), .full(full8), .done(done8));

  instr_encoder #(.ADDR_W(2), .START_ADDR(0)) dut2 (
    .clk(clk), .rst_n(rst2_n), .in_if(if2), .restart(restart2),
    .mem_we(we2), .mem_addr(addr2), .mem_wdata(wdata2), .count(count2),
    .err_illegal(ill2), .err_range(rng2), .full(full2), .done(done2));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  key;
    logic        alusrc;
    logic [2:0]  rs, rt, rd;
    logic [3:0]  funct;
    logic [7:0]  imm;
    logic        wr;
    logic [15:0] word;
  } vec_t;

  vec_t vt[11];

  task automatic set8(input vec_t v, input logic last);
    {if8.in_regdst, if8.in_memtoreg, if8.in_regwrite, if8.in_memread,
     if8.in_memwrite, if8.in_branch, if8.in_aluop} = v.key;
    if8.in_alusrc = v.alusrc;
    if8.in_rs = v.rs; if8.in_rt = v.rt; if8.in_rd = v.rd;
    if8.in_funct = v.funct; if8.in_imm = v.imm; if8.in_last = last;
  endtask

  // R-type bundle into the small DUT; polls in_ready within a cycle budget
  task automatic send2(input logic last, output bit acc);
    acc = 1'b0;
    {if2.in_regdst, if2.in_memtoreg, if2.in_regwrite, if2.in_memread,
     if2.in_memwrite, if2.in_branch, if2.in_aluop} = 8'hA0;
    if2.in_alusrc = 1'b0;
    if2.in_rs = 3'd1; if2.in_rt = 3'd2; if2.in_rd = 3'd3; if2.in_funct = 4'd4;
    if2.in_imm = 8'h00; if2.in_last = last; if2.in_valid = 1'b1;
    for (int c = 0; c < 8 && !acc; c++) begin
      if (if2.in_ready) acc = 1'b1;
      @(negedge clk);
    end
    if2.in_valid = 1'b0;
  endtask

  logic [1:0] wr2_addrs[$];
  always @(negedge clk) if (we2) wr2_addrs.push_back(addr2);

  int exp_addr, exp_count;
  bit acc;
  vec_t v;

  initial begin
    vt[0]  = '{8'hA0, 1'b0, 3'd1, 3'd2, 3'd3, 4'd4, 8'h00, 1'b1, 16'h0534};
    vt[1]  = '{8'h73, 1'b1, 3'd2, 3'd5, 3'd0, 4'd0, 8'hFC, 1'b1, 16'h8AFC};
    vt[2]  = '{8'h28, 1'b0, 3'd1, 3'd1, 3'd1, 4'd1, 8'h01, 1'b0, 16'h0000};
    vt[3]  = '{8'h0B, 1'b1, 3'd3, 3'd4, 3'd0, 4'd0, 8'h10, 1'b1, 16'hAE10};
    vt[4]  = '{8'h05, 1'b0, 3'd1, 3'd2, 3'd0, 4'd0, 8'hFE, 1'b1, 16'hC57E};
    vt[5]  = '{8'h22, 1'b1, 3'd7, 3'd6, 3'd0, 4'd0, 8'h3F, 1'b1, 16'h3F3F};
`ifdef IMM_RANGE_CHECK_EN
    vt[6]  = '{8'h23, 1'b1, 3'd1, 3'd1, 3'd0, 4'd0, 8'h64, 1'b0, 16'h0000};
    vt[10] = '{8'h23, 1'b1, 3'd0, 3'd0, 3'd0, 4'd0, 8'hBF, 1'b0, 16'h0000};
`else
    vt[6]  = '{8'h23, 1'b1, 3'd1, 3'd1, 3'd0, 4'd0, 8'h64, 1'b1, 16'hE4E4};
    vt[10] = '{8'h23, 1'b1, 3'd0, 3'd0, 3'd0, 4'd0, 8'hBF, 1'b1, 16'hE03F};
`endif
    vt[7]  = '{8'hA0, 1'b1, 3'd7, 3'd7, 3'd7, 4'hF, 8'h80, 1'b1, 16'h1FFF};
    vt[8]  = '{8'h23, 1'b1, 3'd0, 3'd0, 3'd0, 4'd0, 8'hC0, 1'b1, 16'hE040};
    vt[9]  = '{8'h23, 1'b1, 3'd0, 3'd0, 3'd0, 4'd0, 8'h3F, 1'b1, 16'hE03F};

    rst8_n = 1'b0; rst2_n = 1'b0; restart8 = 1'b0; restart2 = 1'b0;
    if8.in_valid = 1'b0; if2.in_valid = 1'b0;
    set8(vt[0], 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, if8.in_ready}, 32'd0);
    chk("rst_we", {31'b0, we8}, 32'd0);
    rst8_n = 1'b1; rst2_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", {31'b0, if8.in_ready}, 32'd1);
    chk("idle_we", {31'b0, we8}, 32'd0);
    chk("idle_count", {23'b0, count8}, 32'd0);
    chk("idle_addr", {24'b0, addr8}, 32'd0);
    chk("idle_wdata", {16'b0, wdata8}, 32'd0);
    chk("idle_flags", {28'b0, ill8, rng8, full8, done8}, 32'd0);

    exp_addr = 0; exp_count = 0;
    for (int i = 0; i < 11; i++) begin
      v = vt[i];
      set8(v, 1'b0);
      if8.in_valid = 1'b1;
      chk($sformatf("v%0d_ready_n", i), {31'b0, if8.in_ready}, 32'd1);
      @(negedge clk);
      if8.in_valid = 1'b0;
      chk($sformatf("v%0d_enc_ready", i), {31'b0, if8.in_ready}, 32'd0);
      chk($sformatf("v%0d_enc_we", i), {31'b0, we8}, 32'd0);
      @(negedge clk);
      if (v.wr) exp_count++;
      chk($sformatf("v%0d_we", i), {31'b0, we8}, {31'b0, v.wr});
      if (v.wr) begin
        chk($sformatf("v%0d_addr", i), {24'b0, addr8}, exp_addr);
        chk($sformatf("v%0d_wdata", i), {16'b0, wdata8}, {16'b0, v.word});
        exp_addr++;
      end
      chk($sformatf("v%0d_count", i), {23'b0, count8}, exp_count);
      chk($sformatf("v%0d_ready_n2", i), {31'b0, if8.in_ready}, {31'b0, !v.wr});
      @(negedge clk);
      chk($sformatf("v%0d_ready_n3", i), {31'b0, if8.in_ready}, 32'd1);
      chk($sformatf("v%0d_we_n3", i), {31'b0, we8}, 32'd0);
    end
    chk("err_illegal", {31'b0, ill8}, 32'd1);
`ifdef IMM_RANGE_CHECK_EN
    chk("err_range", {31'b0, rng8}, 32'd1);
`else
    chk("err_range", {31'b0, rng8}, 32'd0);
`endif

    v = '{8'hA0, 1'b0, 3'd0, 3'd0, 3'd0, 4'd1, 8'h00, 1'b1, 16'h0001};
    set8(v, 1'b1);
    if8.in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("last_we", {31'b0, we8}, 32'd1);
    chk("last_addr", {24'b0, addr8}, exp_addr);
    chk("last_wdata", {16'b0, wdata8}, 32'h0001);
    @(negedge clk);
    chk("last_done", {31'b0, done8}, 32'd1);
    chk("last_ready", {31'b0, if8.in_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("done_hold_we", {31'b0, we8}, 32'd0);
    chk("done_hold_count", {23'b0, count8}, exp_count + 1);
    if8.in_valid = 1'b0;
    restart8 = 1'b1;
    @(negedge clk);
    restart8 = 1'b0;
    chk("rs8_ready", {31'b0, if8.in_ready}, 32'd1);
    chk("rs8_count", {23'b0, count8}, 32'd0);
    chk("rs8_flags", {28'b0, ill8, rng8, full8, done8}, 32'd0);

    v = vt[1];
    set8(v, 1'b0);
    if8.in_valid = 1'b1;
    @(negedge clk);
    if8.in_valid = 1'b0;
    rst8_n = 1'b0;
    @(negedge clk);
    chk("midrst_we", {31'b0, we8}, 32'd0);
    rst8_n = 1'b1;
    @(negedge clk);
    chk("midrst_we2", {31'b0, we8}, 32'd0);
    chk("midrst_count", {23'b0, count8}, 32'd0);
    chk("midrst_ready", {31'b0, if8.in_ready}, 32'd1);

    for (int k = 0; k < 5; k++) begin
      send2(1'b0, acc);
      chk($sformatf("fill%0d_accept", k), {31'b0, acc}, {31'b0, k < 4});
    end
    chk("fill_nwrites", wr2_addrs.size(), 32'd4);
    for (int k = 0; k < 4 && k < wr2_addrs.size(); k++)
      chk($sformatf("fill%0d_addr", k), {30'b0, wr2_addrs[k]}, k);
    chk("fill_full", {31'b0, full2}, 32'd1);
    chk("fill_done", {31'b0, done2}, 32'd0);
    chk("fill_count", {29'b0, count2}, 32'd4);
    chk("fill_ready", {31'b0, if2.in_ready}, 32'd0);
    restart2 = 1'b1;
    @(negedge clk);
    restart2 = 1'b0;
    chk("rs2_ready", {31'b0, if2.in_ready}, 32'd1);
    chk("rs2_count", {29'b0, count2}, 32'd0);
    chk("rs2_full", {31'b0, full2}, 32'd0);
    send2(1'b1, acc);
    chk("rs2_accept", {31'b0, acc}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("rs2_nwrites", wr2_addrs.size(), 32'd5);
    if (wr2_addrs.size() == 5) chk("rs2_addr", {30'b0, wr2_addrs[4]}, 32'd0);
    chk("rs2_done", {31'b0, done2}, 32'd1);
    chk("rs2_full2", {31'b0, full2}, 32'd0);
    chk("rs2_count2", {29'b0, count2}, 32'd1);
    chk("ill2", {30'b0, ill2, rng2}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
